// File: rtl/tick_sched_pkg.sv
// ============================================================================
// Module  : tick_sched_pkg
// Brief   : Shared channel-state type and default constants for tick_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    localparam int c_default_w      = 27;
    localparam int c_default_period = 100_000_000;

endpackage

`default_nettype wire

// File: rtl/tick_sched_chan.sv
// ============================================================================
// Module  : tick_sched_chan
// Brief   : One tick channel: period register, counter, IDLE/RUN state and
//           registered one-cycle tick, with optional one-shot behaviour.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_sched_chan
    import tick_sched_pkg::*;
#(
    parameter int W              = c_default_w,
    parameter int DEFAULT_PERIOD = c_default_period
) (
    input  logic         clk100MHz,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_period,
    input  logic         i_load_oneshot,
    input  logic         i_start,
    input  logic         i_stop,
    output logic         o_busy,
    output logic         o_tick_nxt,
    output logic         o_tick
);

    chan_state_t  r_state;
    chan_state_t  w_state_nxt;
    logic [W-1:0] r_period;
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;
    logic         r_oneshot;
    logic         r_tick;
    logic         w_tick_nxt;
    logic         w_wrap;

    // Period is never zero, so P-1 cannot underflow.
    assign w_wrap = (r_count == (r_period - W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (i_start && !i_stop) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stop beats restart, restart beats a tick due this cycle.
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (i_start || i_load) begin
                    w_count_nxt = '0;
                end else if (w_wrap) begin
                    w_count_nxt = '0;
                    w_tick_nxt  = 1'b1;
                    if (r_oneshot) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_count_nxt = r_count + W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_period  <= W'(DEFAULT_PERIOD);
            r_oneshot <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tick  <= w_tick_nxt;
            if (i_load) begin
                r_period  <= i_load_period;
                r_oneshot <= i_load_oneshot;
            end
        end
    end

    assign o_busy     = (r_state == ST_RUN);
    assign o_tick_nxt = w_tick_nxt;
    assign o_tick     = r_tick;

endmodule

`default_nettype wire

// File: rtl/tick_sched.sv
// ============================================================================
// Module  : tick_sched
// Brief   : NCH independent programmable tick generators with write decode
//           and a registered lowest-index tick priority encoder.
//           Optional one-shot mode: define TICK_SCHED_ONESHOT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int W              = c_default_w,
    parameter int DEFAULT_PERIOD = c_default_period,
    localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk100MHz,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W-1:0]   wr_period,
`ifdef TICK_SCHED_ONESHOT_EN
    input  logic           wr_oneshot,
`endif
    output logic           wr_err,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] stop,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] tick,
    output logic           tick_any,
    output logic [CHW-1:0] tick_id,
    output logic           tick_coll
);

    logic           w_ch_valid;
    logic           w_wr_ok;
    logic           w_oneshot;
    logic [NCH-1:0] w_tick_nxt;
    logic [CHW-1:0] w_id_nxt;
    logic           w_coll_nxt;
    logic           r_wr_err;
    logic           r_tick_any;
    logic [CHW-1:0] r_tick_id;
    logic           r_tick_coll;

`ifdef TICK_SCHED_ONESHOT_EN
    assign w_oneshot = wr_oneshot;
`else
    assign w_oneshot = 1'b0;
`endif

    assign w_ch_valid = ({1'b0, wr_ch} < (CHW+1)'(NCH));
    assign w_wr_ok    = wr_en && w_ch_valid && (wr_period != '0);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            tick_sched_chan #(
                .W              (W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_chan (
                .clk100MHz      (clk100MHz),
                .rst            (rst),
                .i_load         (w_wr_ok && (wr_ch == CHW'(i))),
                .i_load_period  (wr_period),
                .i_load_oneshot (w_oneshot),
                .i_start        (start[i]),
                .i_stop         (stop[i]),
                .o_busy         (busy[i]),
                .o_tick_nxt     (w_tick_nxt[i]),
                .o_tick         (tick[i])
            );
        end
    endgenerate

    // Summary flags are computed from next-cycle ticks so they land with tick.
    always_comb begin
        w_id_nxt = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_tick_nxt[i]) begin
                w_id_nxt = CHW'(i);
            end
        end
    end

    assign w_coll_nxt = ((w_tick_nxt & (w_tick_nxt - NCH'(1))) != '0);

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_wr_err    <= 1'b0;
            r_tick_any  <= 1'b0;
            r_tick_id   <= '0;
            r_tick_coll <= 1'b0;
        end else begin
            r_wr_err    <= wr_en && !w_wr_ok;
            r_tick_any  <= |w_tick_nxt;
            r_tick_id   <= w_id_nxt;
            r_tick_coll <= w_coll_nxt;
        end
    end

    assign wr_err    = r_wr_err;
    assign tick_any  = r_tick_any;
    assign tick_id   = r_tick_id;
    assign tick_coll = r_tick_coll;

endmodule

`default_nettype wire

// File: tb/tb_tick_sched.sv
// ============================================================================
// Module  : tb_tick_sched
// Brief   : Self-checking bench for tick_sched with a per-cycle scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_sched;
    import tick_sched_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 27;
    localparam int DP  = 100_000_000;

    logic           clk100MHz = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [W-1:0]   wr_period;
    logic           wr_oneshot;
    logic           wr_err;
    logic [NCH-1:0] start, stop, busy, tick;
    logic           tick_any, tick_coll;
    logic [1:0]     tick_id;

    logic           wr_en3;
    logic [1:0]     wr_ch3;
    logic [W-1:0]   wr_period3;
    logic           wr_err3;
    logic [2:0]     start3, stop3, busy3, tick3;
    logic           tick_any3, tick_coll3;
    logic [1:0]     tick_id3;

    typedef struct {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk100MHz = ~clk100MHz;

    tick_sched #(.NCH(NCH), .W(W), .DEFAULT_PERIOD(DP)) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_period (wr_period),
`ifdef TICK_SCHED_ONESHOT_EN
        .wr_oneshot(wr_oneshot),
`endif
        .wr_err    (wr_err),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .tick      (tick),
        .tick_any  (tick_any),
        .tick_id   (tick_id),
        .tick_coll (tick_coll)
    );

    tick_sched #(.NCH(3), .W(W), .DEFAULT_PERIOD(DP)) dut3 (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .wr_en     (wr_en3),
        .wr_ch     (wr_ch3),
        .wr_period (wr_period3),
`ifdef TICK_SCHED_ONESHOT_EN
        .wr_oneshot(1'b0),
`endif
        .wr_err    (wr_err3),
        .start     (start3),
        .stop      (stop3),
        .busy      (busy3),
        .tick      (tick3),
        .tick_any  (tick_any3),
        .tick_id   (tick_id3),
        .tick_coll (tick_coll3)
    );

    task automatic step();
        @(posedge clk100MHz);
        #1;
    endtask

    task automatic wr(input int ch, input int p, input bit os = 1'b0);
        wr_en      = 1'b1;
        wr_ch      = 2'(ch);
        wr_period  = W'(p);
        wr_oneshot = os;
        step();
        wr_en      = 1'b0;
        wr_oneshot = 1'b0;
    endtask

    function automatic logic [1:0] lowest(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic multi(input logic [NCH-1:0] v);
        int n = 0;
        for (int i = 0; i < NCH; i++) n += int'(v[i]);
        return n >= 2;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, tick, tick_any, tick_id, tick_coll, wr_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b tick=%b any=%b id=%0d coll=%b err=%b required all 0",
                     busy, tick, tick_any, tick_id, tick_coll, wr_err);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (dut.g_chan[0].u_chan.r_period !== W'(DP)) begin
            errors++;
            $display("FAIL reset_period actual=%0d required=%0d", dut.g_chan[0].u_chan.r_period, DP);
        end
    endtask

    task automatic test_period4();
        wr(0, 4);
        start = 4'b0001;
        for (int k = 0; k < 14; k++)
            sb.push_back('{tick: ((k > 0) && (k % 4 == 0)) ? 4'b0001 : 4'b0000, busy: 4'b0001});
        for (int k = 0; k < 14; k++) begin
            step();
            start = '0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.tick || busy !== e.busy || tick_any !== (|e.tick)) begin
                errors++;
                $display("FAIL period4 k=%0d tick=%b busy=%b any=%b required tick=%b busy=%b",
                         k, tick, busy, tick_any, e.tick, e.busy);
            end
        end
        stop = 4'b0001;
        step();
        stop = '0;
        checks++;
        if (busy !== 4'b0000) begin
            errors++;
            $display("FAIL period4_stop busy=%b required 0000", busy);
        end
    endtask

    task automatic test_collision();
        wr(0, 3);
        wr(1, 6);
        start = 4'b0011;
        for (int k = 0; k < 8; k++)
            sb.push_back('{tick: {2'b00, (k > 0) && (k % 6 == 0), (k > 0) && (k % 3 == 0)},
                           busy: 4'b0011});
        for (int k = 0; k < 8; k++) begin
            step();
            start = '0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.tick || busy !== e.busy || tick_any !== (|e.tick) ||
                tick_id !== lowest(e.tick) || tick_coll !== multi(e.tick)) begin
                errors++;
                $display("FAIL collision k=%0d tick=%b id=%0d coll=%b busy=%b required tick=%b id=%0d coll=%b busy=%b",
                         k, tick, tick_id, tick_coll, busy, e.tick, lowest(e.tick), multi(e.tick), e.busy);
            end
        end
        stop = 4'b0011;
        step();
        stop = '0;
    endtask

    task automatic test_wr_err();
        wr(2, 0);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_zero actual=%b required=1", wr_err);
        end
        step();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_pulse_len actual=%b required=0", wr_err);
        end
        checks++;
        if (dut.g_chan[2].u_chan.r_period !== W'(DP)) begin
            errors++;
            $display("FAIL wr_err_period actual=%0d required=%0d", dut.g_chan[2].u_chan.r_period, DP);
        end
        wr(3, 7);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_ok_no_err actual=%b required=0", wr_err);
        end
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_period3 = W'(5);
        step();
        wr_en3 = 1'b0;
        checks++;
        if (wr_err3 !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_bad_ch actual=%b required=1", wr_err3);
        end
        wr_en3 = 1'b1; wr_ch3 = 2'd2;
        step();
        wr_en3 = 1'b0;
        checks++;
        if (wr_err3 !== 1'b0 || dut3.g_chan[2].u_chan.r_period !== W'(5)) begin
            errors++;
            $display("FAIL wr_ok_ch2 err=%b period=%0d required err=0 period=5",
                     wr_err3, dut3.g_chan[2].u_chan.r_period);
        end
    endtask

    task automatic test_stop();
        wr(0, 5);
        start = 4'b0001;
        for (int k = 0; k < 7; k++)
            sb.push_back('{tick: 4'b0000, busy: (k < 5) ? 4'b0001 : 4'b0000});
        for (int k = 0; k < 7; k++) begin
            step();
            start = '0;
            stop  = '0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.tick || busy !== e.busy) begin
                errors++;
                $display("FAIL stop k=%0d tick=%b busy=%b required tick=%b busy=%b",
                         k, tick, busy, e.tick, e.busy);
            end
            if (k == 4) begin
                start = 4'b0010;
                stop  = 4'b0011;
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_ch = 2'd2; wr_period = W'(2);
        start = 4'b0100;
        for (int k = 0; k < 15; k++)
            sb.push_back('{tick: (k == 2 || k == 4 || k == 6 || k == 10 || k == 13) ? 4'b0100 : 4'b0000,
                           busy: 4'b0100});
        for (int k = 0; k < 15; k++) begin
            step();
            wr_en = 1'b0;
            start = '0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.tick || busy !== e.busy || tick_id !== lowest(e.tick)) begin
                errors++;
                $display("FAIL back_to_back k=%0d tick=%b busy=%b id=%0d required tick=%b busy=%b id=%0d",
                         k, tick, busy, tick_id, e.tick, e.busy, lowest(e.tick));
            end
            if (k == 6) begin
                wr_en = 1'b1; wr_ch = 2'd2; wr_period = W'(3);
            end
        end
        stop = 4'b0100;
        step();
        stop = '0;
    endtask

    task automatic test_reset_mid();
        int seen;
        wr(0, 4);
        start = 4'b0001;
        step();
        start = '0;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, tick, tick_any, tick_id, tick_coll, wr_err} !== '0) begin
            errors++;
            $display("FAIL reset_async busy=%b tick=%b any=%b id=%0d coll=%b err=%b required all 0",
                     busy, tick, tick_any, tick_id, tick_coll, wr_err);
        end
        #2;
        rst = 1'b0;
        checks++;
        if (dut.g_chan[0].u_chan.r_period !== W'(DP)) begin
            errors++;
            $display("FAIL reset_mid_period actual=%0d required=%0d", dut.g_chan[0].u_chan.r_period, DP);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick !== '0 || busy !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet active_cycles=%0d required=0", seen);
        end
    endtask

`ifdef TICK_SCHED_ONESHOT_EN
    task automatic test_oneshot();
        wr(3, 2, 1'b1);
        start = 4'b1000;
        for (int k = 0; k < 7; k++)
            sb.push_back('{tick: (k == 2) ? 4'b1000 : 4'b0000, busy: (k < 2) ? 4'b1000 : 4'b0000});
        for (int k = 0; k < 7; k++) begin
            step();
            start = '0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.tick || busy !== e.busy) begin
                errors++;
                $display("FAIL oneshot k=%0d tick=%b busy=%b required tick=%b busy=%b",
                         k, tick, busy, e.tick, e.busy);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_oneshot = 1'b0;
        start = '0; stop = '0;
        wr_en3 = 1'b0; wr_ch3 = '0; wr_period3 = '0; start3 = '0; stop3 = '0;
        test_reset();
        test_period4();
        test_collision();
        test_wr_err();
        test_stop();
        test_back_to_back();
        test_reset_mid();
`ifdef TICK_SCHED_ONESHOT_EN
        test_oneshot();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter NCH, default 4: number of independent tick channels (1..8).
REQ-002 Parameter W, default 27: period/counter width in bits.
REQ-003 Parameter DEFAULT_PERIOD, default 100_000_000: per-channel period after reset (1 Hz tick at 100 MHz).
REQ-004 clk100MHz  input  1  system clock, single clock domain, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  period-write strobe, one cycle.
REQ-007 wr_ch  input  $clog2(NCH)  target channel of write.
REQ-008 wr_period  input  W  new period in clk100MHz cycles.
REQ-009 wr_err  output  1  one-cycle pulse: write rejected.
REQ-010 start  input  NCH  per-channel start pulse.
REQ-011 stop  input  NCH  per-channel stop pulse.
REQ-012 busy  output  NCH  channel in RUN.
REQ-013 tick  output  NCH  per-channel one-cycle enable pulse, registered.
REQ-014 tick_any  output  1  OR of tick, registered with tick.
REQ-015 tick_id  output  $clog2(NCH)  lowest-index channel ticking this cycle; 0 when tick_any=0.
REQ-016 tick_coll  output  1  high when two or more tick bits are high in the same cycle.

Function
REQ-017 Each channel holds period register P, counter C (both W bits) and state IDLE or RUN.
REQ-018 IDLE: C held at 0, no tick; start -> RUN with C=0 on next edge.
REQ-019 RUN: C increments each cycle; when C==P-1, C wraps to 0 and tick pulses the following cycle, giving exactly one tick every P cycles, first tick P cycles after the start edge.
REQ-020 stop in RUN -> IDLE, C=0; a tick due in that cycle is suppressed.
REQ-021 start and stop in the same cycle: stop wins; start to an already-RUN channel restarts C at 0.
REQ-022 wr_en with wr_period>=1 loads P[wr_ch]; if that channel is RUN, C restarts at 0 and the next tick follows the new period.
REQ-023 wr_en with wr_period==0: P unchanged, wr_err pulses next cycle.
REQ-024 wr_en with wr_ch>=NCH: ignored, wr_err pulses.
REQ-025 Write and start to the same channel in one cycle: new P used for the first period.
REQ-026 tick_any, tick_id, tick_coll derived from the same registered tick vector; no extra latency versus tick.

Reset
REQ-027 rst assertion immediately forces: all channels IDLE, C=0, P=DEFAULT_PERIOD, tick=0, busy=0, tick_any=0, tick_id=0, tick_coll=0, wr_err=0.
REQ-028 Reset mid-count discards pending ticks; first activity after release requires a new start.

Configuration
REQ-029 Macro TICK_SCHED_ONESHOT_EN defined: extra input wr_oneshot (1 bit) is stored per channel on valid writes (reset 0); a one-shot channel returns to IDLE on the edge its tick is produced, busy falling with the tick.
REQ-030 Macro undefined: wr_oneshot port absent, all channels periodic only.

Structure
REQ-031 Package tick_sched_pkg holds the channel-state type (IDLE, RUN), default W and DEFAULT_PERIOD constants.
REQ-032 Sub-module tick_sched_chan implements one channel (P, C, state, tick, oneshot); tick_sched instantiates NCH copies and the write decode plus tick priority encoder.

Verification
REQ-033 P=4 on ch0, start ch0 at cycle 0 -> tick[0] at cycles 4, 8, 12; busy[0]=1 from cycle 1.
REQ-034 ch0 P=3, ch1 P=6, both started together -> at cycle 6 tick=0b0011, tick_id=0, tick_coll=1; at cycle 3 tick_id=0, tick_coll=0.
REQ-035 wr_period=0 to ch2 -> wr_err one cycle, P[2] stays 100_000_000.
REQ-036 ch0 P=5 running, stop on the cycle C==4 -> no tick, busy[0]=0 next cycle; start+stop same cycle on idle ch1 -> stays IDLE.
REQ-037 rst asserted mid-period with ch0 running -> all outputs 0 asynchronously, P[0]=DEFAULT_PERIOD after release, no tick until start.
REQ-038 With TICK_SCHED_ONESHOT_EN, P=2, oneshot=1, start -> single tick at cycle 2, busy low thereafter.
